// File: rtl/frame_sync_pkg.sv
// Shared types and helpers for the frame synchroniser: FSM state encoding,
// a constant-evaluable clog2 and the default frame geometry.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_FRAME_LEN  = 16;
  localparam int DEF_LOCK_CNT   = 3;
  localparam int DEF_UNLOCK_CNT = 2;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/equal_const.sv
// Combinational compare of a word against a constant; zero latency, no flow control.
// METHOD 0 uses a plain equality, METHOD 1 an explicit ripple AND chain.
module equal_const #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] CONST_VAL = '0,
  parameter int               METHOD    = 0
) (
  input  logic [WIDTH-1:0] i_din,
  output logic             o_eq
);

  generate
    if (METHOD == 1) begin : g_chain
      logic [WIDTH:0] w_chain;
      assign w_chain[0] = 1'b1;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_chain[i+1] = w_chain[i] & (i_din[i] ~^ CONST_VAL[i]);
      end
      assign o_eq = w_chain[WIDTH];
    end else begin : g_generic
      assign o_eq = (i_din == CONST_VAL);
    end
  endgenerate

endmodule

// File: rtl/frame_sync_lock.sv
// Sync-word hunter/verifier/flywheel; din->dout latency 2 cycles, din_valid=0 freezes state (no backpressure).
// Optional FRAME_SYNC_STATS_EN adds a saturating loss_count of LOCKED->HUNT drops.
module frame_sync_lock
  import frame_sync_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD  = 8'h45,
  parameter int               FRAME_LEN  = DEF_FRAME_LEN,
  parameter int               LOCK_CNT   = DEF_LOCK_CNT,
  parameter int               UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int               METHOD     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             locked,
  output logic             sync_err
`ifdef FRAME_SYNC_STATS_EN
  ,
  output logic [15:0]      loss_count
`endif
);

  localparam int PW = clog2(FRAME_LEN);
  localparam int GW = clog2(LOCK_CNT + 1);
  localparam int MW = clog2(UNLOCK_CNT + 1);

  logic [WIDTH-1:0] r_d1;
  logic             r_v1;
  state_t           r_state;
  logic [PW-1:0]    r_pos;
  logic [GW-1:0]    r_good;
  logic [MW-1:0]    r_miss;

  logic             w_match;
  logic             w_slot;
  logic             w_err;
  state_t           w_state_nx;
  logic [PW-1:0]    w_pos_nx;
  logic [PW-1:0]    w_pos_inc;
  logic [GW-1:0]    w_good_nx;
  logic [GW-1:0]    w_good_inc;
  logic [MW-1:0]    w_miss_nx;
  logic [MW-1:0]    w_miss_inc;

  equal_const #(
    .WIDTH    (WIDTH),
    .CONST_VAL(SYNC_WORD),
    .METHOD   (METHOD)
  ) u_match (
    .i_din(r_d1),
    .o_eq (w_match)
  );

  assign w_slot     = (r_pos == '0);
  assign w_pos_inc  = (r_pos == PW'(FRAME_LEN - 1)) ? '0 : r_pos + PW'(1);
  assign w_good_inc = r_good + GW'(1);
  assign w_miss_inc = r_miss + MW'(1);

  // pos is kept at 0 throughout HUNT so a single-sync lock still lands on the slot.
  always_comb begin
    w_state_nx = r_state;
    w_pos_nx   = r_pos;
    w_good_nx  = r_good;
    w_miss_nx  = r_miss;
    w_err      = 1'b0;
    if (r_v1) begin
      case (r_state)
        HUNT: begin
          if (w_match) begin
            w_pos_nx   = PW'(1);
            w_good_nx  = GW'(1);
            w_state_nx = (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (!w_slot) begin
            w_pos_nx = w_pos_inc;
          end else if (w_match) begin
            w_pos_nx  = w_pos_inc;
            w_good_nx = w_good_inc;
            if (w_good_inc == GW'(LOCK_CNT)) w_state_nx = LOCKED;
          end else begin
            w_state_nx = HUNT;
            w_good_nx  = '0;
            w_pos_nx   = '0;
          end
        end
        LOCKED: begin
          w_pos_nx = w_pos_inc;
          if (w_slot && w_match) begin
            w_miss_nx = '0;
          end else if (w_slot) begin
            w_err     = 1'b1;
            w_miss_nx = w_miss_inc;
            if (w_miss_inc == MW'(UNLOCK_CNT)) begin
              w_state_nx = HUNT;
              w_miss_nx  = '0;
              w_pos_nx   = '0;
            end
          end
        end
        default: begin
          w_state_nx = HUNT;
          w_pos_nx   = '0;
          w_good_nx  = '0;
          w_miss_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1       <= '0;
      r_v1       <= 1'b0;
      r_state    <= HUNT;
      r_pos      <= '0;
      r_good     <= '0;
      r_miss     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      r_d1       <= din;
      r_v1       <= din_valid;
      r_state    <= w_state_nx;
      r_pos      <= w_pos_nx;
      r_good     <= w_good_nx;
      r_miss     <= w_miss_nx;
      dout       <= r_d1;
      dout_valid <= r_v1 && (w_state_nx == LOCKED);
      sof        <= r_v1 && w_slot && (w_state_nx == LOCKED);
      locked     <= (w_state_nx == LOCKED);
      sync_err   <= w_err;
    end
  end

`ifdef FRAME_SYNC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_count <= '0;
    end else if ((r_state == LOCKED) && (w_state_nx == HUNT) && (loss_count != 16'hFFFF)) begin
      loss_count <= loss_count + 16'd1;
    end
  end
`endif

endmodule
